stage_ifid_q: RTL

- Parametrised IF/ID pipeline stage for the rv32i core, sitting between instruction fetch (PC + I-cache) and decode.
- Adds a small holding FIFO, so fetch responses that arrive during a decode stall are kept, not lost.
- Adds a programmable wrong-path kill window after branch/jump flush, and a valid bit on the decode side.
- Replaces the fixed two-bubble stall/flush register with a width/depth/latency-configurable block.

---
 rtl/stage_ifid_q.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/stage_ifid_q.sv
// IF/ID pipeline stage with a small holding FIFO, a programmable wrong-path
// kill window after a redirect, and a valid bit on the decode side.
module stage_ifid_q #(
  parameter int unsigned   PC_WIDTH    = 32,
  parameter int unsigned   DATA_WIDTH  = 32,
  parameter int unsigned   DEPTH       = 2,
  parameter int unsigned   KILL_CYCLES = 2,
  parameter logic [31:0]   NOP_VALUE   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PC_WIDTH-1:0]        pc_i,
  input  logic [DATA_WIDTH-1:0]      inst_i,
  input  logic                       valid_i,
  input  logic                       stall,
  input  logic                       flush,
  output logic [PC_WIDTH-1:0]        pc_o,
  output logic [DATA_WIDTH-1:0]      inst_o,
  output logic                       valid_o,
  output logic                       fetch_hold_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [1:0]                 state_o,
  output logic                       ovf_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]         HOLD_C  = CW'(DEPTH - 1);
  localparam logic [2:0]            KILL_LD = 3'(KILL_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] NOP_C   = DATA_WIDTH'(NOP_VALUE);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_KILL = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              kill_q, kill_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]           wptr_q, wptr_d;
  logic [PW-1:0]           rptr_q, rptr_d;
  logic [PC_WIDTH-1:0]     mem_pc_q   [DEPTH];
  logic [PC_WIDTH-1:0]     mem_pc_d   [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_inst_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_inst_d [DEPTH];
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   inst_q, inst_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;
  logic                    push_s, pop_s;

  // Next-state logic: flush beats the kill window, which beats stall.
  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    mem_pc_d   = mem_pc_q;
    mem_inst_d = mem_inst_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    push_s     = 1'b0;
    pop_s      = 1'b0;

    if (flush) begin
      inst_d  = NOP_C;
      valid_d = 1'b0;
      kill_d  = KILL_LD;
      if (KILL_CYCLES > 1) begin
        state_d = ST_KILL;
      end else begin
        state_d = stall ? ST_HOLD : ST_RUN;
      end
    end else if (state_q == ST_KILL) begin
      inst_d  = NOP_C;
      valid_d = 1'b0;
      if (kill_q <= 3'd1) begin
        kill_d  = 3'd0;
        state_d = stall ? ST_HOLD : ST_RUN;
      end else begin
        kill_d  = kill_q - 3'd1;
      end
    end else if (stall) begin
      state_d = ST_HOLD;
      if (valid_i && (cnt_q < DEPTH_C)) begin
        push_s = 1'b1;
      end else if (valid_i) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      state_d = ST_RUN;
      if (cnt_q != {CW{1'b0}}) begin
        pop_s   = 1'b1;
        push_s  = valid_i;
        pc_d    = mem_pc_q[rptr_q];
        inst_d  = mem_inst_q[rptr_q];
        valid_d = 1'b1;
      end else if (valid_i) begin
        pc_d    = pc_i;
        inst_d  = inst_i;
        valid_d = 1'b1;
      end else begin
        inst_d  = NOP_C;
        valid_d = 1'b0;
      end
    end

    if (push_s) begin
      mem_pc_d[wptr_q]   = pc_i;
      mem_inst_d[wptr_q] = inst_i;
      wptr_d             = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end

    if (flush) begin
      cnt_d  = {CW{1'b0}};
      wptr_d = {PW{1'b0}};
      rptr_d = {PW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      kill_q  <= 3'd0;
      cnt_q   <= {CW{1'b0}};
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      pc_q    <= {PC_WIDTH{1'b0}};
      inst_q  <= NOP_C;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // FIFO storage; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    mem_pc_q   <= mem_pc_d;
    mem_inst_q <= mem_inst_d;
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign valid_o      = valid_q;
  assign count_o      = cnt_q;
  assign state_o      = state_q;
  assign ovf_o        = ovf_q;
  assign fetch_hold_o = (cnt_q >= HOLD_C);

endmodule
